mips_sopc: RTL and testbench

//  Minimal MIPS32 system-on-chip top: 5-stage in-order pipelined integer core
//  (IF/ID/EX/MEM/WB) plus on-chip instruction ROM. Only clock and reset pins;

---
 rtl/mips_sopc_pkg.sv | 89 ++++++++
 rtl/mips_sopc_if.sv | 17 +
 rtl/mips_sopc_inst_rom.sv | 38 +++
 rtl/mips_sopc.sv | 198 +++++++++++++++++++
 tb/tb_mips_sopc.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_sopc_pkg.sv
// Shared definitions for the mips_sopc core: widths, ISA encodings,
// ALU operation set, pipeline-stage payload structs and the ALU datapath.
package mips_defs_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  // Reset level of the rst pin (active low).
  localparam logic RST_ACTIVE = 1'b0;

  // sll $0,$0,0 -- the canonical no-op, also what a disabled ROM returns.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef logic [DATA_W-1:0]                   word_t;
  typedef logic [REG_AW-1:0]                   reg_addr_t;
  typedef logic [NUM_REGS-1:0][DATA_W-1:0]     regfile_t;

  // Decoded instruction travelling from ID into EX. For shifts, a carries
  // the shift amount and b the value being shifted.
  typedef struct packed {
    alu_op_e   op;
    word_t     a;
    word_t     b;
    logic      wreg;
    reg_addr_t waddr;
  } ex_ctrl_t;

  // Result travelling from EX towards write-back.
  typedef struct packed {
    logic      wreg;
    reg_addr_t waddr;
    word_t     wdata;
  } wb_ctrl_t;

  localparam ex_ctrl_t EX_NOP = '{op: ALU_NOP, a: '0, b: '0, wreg: 1'b0, waddr: '0};
  localparam wb_ctrl_t WB_NOP = '{wreg: 1'b0, waddr: '0, wdata: '0};

  // 32-bit wrap-around ALU; shift distance is the low five bits of a.
  function automatic word_t alu_calc(alu_op_e op, word_t a, word_t b);
    word_t res;
    case (op)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_NOR: res = ~(a | b);
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SLL: res = b << a[4:0];
      ALU_SRL: res = b >> a[4:0];
      ALU_SRA: res = word_t'($signed(b) >>> a[4:0]);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mips_sopc_if.sv
// Instruction-fetch bus between the core (master) and the instruction ROM
// (slave).
//
// Handshake: ce acts as the request valid and qualifies addr. There is no
// ready: the ROM always accepts and answers combinationally in the same
// cycle, so inst is valid whenever ce is high and reads 0 (a NOP) while
// ce is low.
interface mips_sopc_if;
  import mips_defs_pkg::*;

  logic  ce;
  word_t addr;
  word_t inst;

  modport master (output ce, output addr, input inst);
  modport slave  (input ce, input addr, output inst);
endinterface

// File: rtl/mips_sopc_inst_rom.sv
// Instruction ROM, ROM_DEPTH 32-bit words, asynchronous read.
// The word index is addr[IDX_W+1:2], so addresses wrap every ROM_DEPTH
// words (ROM_DEPTH is expected to be a power of two). The image named by
// ROM_FILE is placed into rom_mem by the build / simulation flow; an empty
// name builds a blank ROM that only ever returns NOPs.
module inst_rom
  import mips_defs_pkg::*;
#(
  parameter int    ROM_DEPTH = 1024,
  parameter string ROM_FILE  = "inst_rom.data"
) (
  mips_sopc_if.slave bus
);

  localparam int IDX_W = $clog2(ROM_DEPTH);

  word_t rom_mem [ROM_DEPTH];

  if (ROM_FILE == "") begin : g_blank
    // No image: every fetch sees a NOP.
    assign bus.inst = NOP_INST;
  end else begin : g_image
    logic [IDX_W-1:0] word_idx;
    logic             unused_addr_bits;

    assign word_idx         = bus.addr[IDX_W+1:2];
    assign unused_addr_bits = ^{bus.addr[DATA_W-1:IDX_W+2], bus.addr[1:0]};

    // Combinational read; a disabled ROM returns 0.
    always_comb begin
      bus.inst = NOP_INST;
      if (bus.ce) begin
        bus.inst = rom_mem[word_idx];
      end
    end
  end

endmodule

// File: rtl/mips_sopc.sv
// Minimal MIPS32 SoC: 5-stage in-order integer pipeline (IF/ID/EX/MEM/WB)
// with a 32x32 register file and an on-chip instruction ROM. All data
// hazards are resolved in ID by forwarding, so the pipe never stalls.
module mips_sopc
  import mips_defs_pkg::*;
#(
  parameter int    ROM_DEPTH = 1024,
  parameter string ROM_FILE  = "inst_rom.data"
) (
  input  logic clk,
  input  logic rst
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  word_t    pc_q, pc_d;
  logic     ce_q, ce_d;
  word_t    if_id_inst_q, if_id_inst_d;
  ex_ctrl_t id_ex_q, id_ex_d;
  wb_ctrl_t ex_mem_q, ex_mem_d;
  wb_ctrl_t mem_wb_q, mem_wb_d;
  regfile_t regs_q, regs_d;

  mips_sopc_if rom_bus ();

  inst_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .ROM_FILE  (ROM_FILE)
  ) u_rom (
    .bus (rom_bus)
  );

  assign rom_bus.ce   = ce_q;
  assign rom_bus.addr = pc_q;

  // ---------------------------------------------------------------------
  // IF: fetching is enabled one edge after reset release; the PC holds 0
  // until then, so address 0 is the first one fetched.
  // ---------------------------------------------------------------------
  // Next fetch enable and program counter.
  always_comb begin
    ce_d = 1'b1;
    pc_d = ce_q ? (pc_q + 32'd4) : '0;
  end

  assign if_id_inst_d = rom_bus.inst;

  // ---------------------------------------------------------------------
  // ID: decode, operand read and forwarding
  // ---------------------------------------------------------------------
  logic [5:0]  id_op, id_fn;
  reg_addr_t   id_rs, id_rt, id_rd;
  logic [4:0]  id_sh;
  logic [15:0] id_imm;
  word_t       rs_val, rt_val;

  assign id_op  = if_id_inst_q[31:26];
  assign id_rs  = if_id_inst_q[25:21];
  assign id_rt  = if_id_inst_q[20:16];
  assign id_rd  = if_id_inst_q[15:11];
  assign id_sh  = if_id_inst_q[10:6];
  assign id_fn  = if_id_inst_q[5:0];
  assign id_imm = if_id_inst_q[15:0];

  // Youngest producer wins: EX result, then MEM, then the write-back of
  // this very cycle, then the register file. $0 always reads as zero.
  function automatic word_t read_operand(reg_addr_t ra, wb_ctrl_t ex_res,
                                         wb_ctrl_t mem_res, wb_ctrl_t wb_res,
                                         regfile_t rf);
    word_t val;
    if (ra == '0) begin
      val = '0;
    end else if (ex_res.wreg && (ex_res.waddr == ra)) begin
      val = ex_res.wdata;
    end else if (mem_res.wreg && (mem_res.waddr == ra)) begin
      val = mem_res.wdata;
    end else if (wb_res.wreg && (wb_res.waddr == ra)) begin
      val = wb_res.wdata;
    end else begin
      val = rf[ra];
    end
    return val;
  endfunction

  // Forwarded source operands for the instruction in ID.
  always_comb begin
    rs_val = read_operand(id_rs, ex_mem_d, mem_wb_d, mem_wb_q, regs_q);
    rt_val = read_operand(id_rt, ex_mem_d, mem_wb_d, mem_wb_q, regs_q);
  end

  // Decode into ALU op, operands and destination. Anything unsupported,
  // or anything targeting $0, collapses to a bubble that writes nothing.
  always_comb begin
    id_ex_d = EX_NOP;
    case (id_op)
      OP_SPECIAL: begin
        id_ex_d.wreg  = 1'b1;
        id_ex_d.waddr = id_rd;
        id_ex_d.a     = rs_val;
        id_ex_d.b     = rt_val;
        case (id_fn)
          FN_AND:  id_ex_d.op = ALU_AND;
          FN_OR:   id_ex_d.op = ALU_OR;
          FN_XOR:  id_ex_d.op = ALU_XOR;
          FN_NOR:  id_ex_d.op = ALU_NOR;
          FN_ADDU: id_ex_d.op = ALU_ADD;
          FN_SUBU: id_ex_d.op = ALU_SUB;
          FN_SLL: begin
            id_ex_d.op = ALU_SLL;
            id_ex_d.a  = {27'd0, id_sh};
          end
          FN_SRL: begin
            id_ex_d.op = ALU_SRL;
            id_ex_d.a  = {27'd0, id_sh};
          end
          FN_SRA: begin
            id_ex_d.op = ALU_SRA;
            id_ex_d.a  = {27'd0, id_sh};
          end
          default: id_ex_d.wreg = 1'b0;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        id_ex_d.wreg  = 1'b1;
        id_ex_d.waddr = id_rt;
        id_ex_d.a     = rs_val;
        id_ex_d.b     = {16'd0, id_imm};
        id_ex_d.op    = (id_op == OP_ANDI) ? ALU_AND :
                        (id_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_ADDIU: begin
        id_ex_d.wreg  = 1'b1;
        id_ex_d.waddr = id_rt;
        id_ex_d.a     = rs_val;
        id_ex_d.b     = {{16{id_imm[15]}}, id_imm};
        id_ex_d.op    = ALU_ADD;
      end
      OP_LUI: begin
        id_ex_d.wreg  = 1'b1;
        id_ex_d.waddr = id_rt;
        id_ex_d.a     = '0;
        id_ex_d.b     = {id_imm, 16'd0};
        id_ex_d.op    = ALU_OR;
      end
      default: id_ex_d = EX_NOP;
    endcase
    if (!id_ex_d.wreg || (id_ex_d.waddr == '0)) begin
      id_ex_d = EX_NOP;
    end
  end

  // ---------------------------------------------------------------------
  // EX: ALU
  // ---------------------------------------------------------------------
  // Execute the decoded operation.
  always_comb begin
    ex_mem_d.wreg  = id_ex_q.wreg;
    ex_mem_d.waddr = id_ex_q.waddr;
    ex_mem_d.wdata = alu_calc(id_ex_q.op, id_ex_q.a, id_ex_q.b);
  end

  // MEM has no memory access in this ISA subset; it only carries the result.
  assign mem_wb_d = ex_mem_q;

  // ---------------------------------------------------------------------
  // WB: register file write port
  // ---------------------------------------------------------------------
  // Commit the write-back result; $0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (mem_wb_q.wreg && (mem_wb_q.waddr != '0)) begin
      regs_d[mem_wb_q.waddr] = mem_wb_q.wdata;
    end
  end

  // All architectural and pipeline state; reset flushes every stage to NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      pc_q         <= '0;
      ce_q         <= 1'b0;
      if_id_inst_q <= NOP_INST;
      id_ex_q      <= EX_NOP;
      ex_mem_q     <= WB_NOP;
      mem_wb_q     <= WB_NOP;
      regs_q       <= '0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      if_id_inst_q <= if_id_inst_d;
      id_ex_q      <= id_ex_d;
      ex_mem_q     <= ex_mem_d;
      mem_wb_q     <= mem_wb_d;
      regs_q       <= regs_d;
    end
  end

endmodule

// File: tb/tb_mips_sopc.sv
// Bench for mips_sopc: directed programs plus random programs, checked
// against an instruction-level interpreter of the supported ISA.
module tb_mips_sopc;

  localparam int NREG = 32;

  localparam logic [5:0] T_ADDIU = 6'h09;
  localparam logic [5:0] T_ANDI  = 6'h0c;
  localparam logic [5:0] T_ORI   = 6'h0d;
  localparam logic [5:0] T_XORI  = 6'h0e;
  localparam logic [5:0] T_LUI   = 6'h0f;
  localparam logic [5:0] T_LW    = 6'h23;
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  mips_sopc dut (
    .clk (clk),
    .rst (rst)
  );

  // Observation copy of the fetch bus.
  mips_sopc_if mon_if ();
  assign mon_if.ce   = dut.rom_bus.ce;
  assign mon_if.addr = dut.rom_bus.addr;
  assign mon_if.inst = dut.rom_bus.inst;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] prog [$];
  logic [31:0] model_regs [NREG];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [5:0]  fns [9] = '{F_AND, F_OR, F_XOR, F_NOR, F_ADDU, F_SUBU, F_SLL, F_SRL, F_SRA};
    logic [5:0]  ops [5] = '{T_ANDI, T_ORI, T_XORI, T_ADDIU, T_LUI};
    int          k, rs, rt, rd, sh;
    logic [15:0] imm;
    k   = $urandom_range(0, 15);
    rs  = $urandom_range(0, 7);
    rt  = $urandom_range(0, 7);
    rd  = $urandom_range(0, 7);
    sh  = $urandom_range(0, 31);
    imm = 16'($urandom);
    if (k < 9)       return enc_r(fns[k], rs, rt, rd, sh);
    else if (k < 14) return enc_i(ops[k-9], rs, rt, imm);
    else if (k == 14) return enc_i(T_LW, rs, rt, imm);
    else             return enc_r(6'h3f, rs, rt, rd, sh);
  endfunction

  // ---------------- reference model: sequential ISA interpreter ----------------
  function automatic void model_exec(input logic [31:0] inst);
    logic [5:0]  op, fn;
    int          rs, rt, rd, sh, dst;
    logic [31:0] s, t, val;
    op  = inst[31:26];
    fn  = inst[5:0];
    rs  = int'(inst[25:21]);
    rt  = int'(inst[20:16]);
    rd  = int'(inst[15:11]);
    sh  = int'(inst[10:6]);
    s   = model_regs[rs];
    t   = model_regs[rt];
    val = '0;
    if (op == 6'h00) begin
      dst = rd;
      case (fn)
        F_AND:   val = s & t;
        F_OR:    val = s | t;
        F_XOR:   val = s ^ t;
        F_NOR:   val = ~(s | t);
        F_ADDU:  val = s + t;
        F_SUBU:  val = s - t;
        F_SLL:   val = t << sh;
        F_SRL:   val = t >> sh;
        F_SRA:   val = 32'($signed(t) >>> sh);
        default: dst = 0;
      endcase
    end else begin
      dst = rt;
      case (op)
        T_ANDI:  val = s & {16'h0, inst[15:0]};
        T_ORI:   val = s | {16'h0, inst[15:0]};
        T_XORI:  val = s ^ {16'h0, inst[15:0]};
        T_ADDIU: val = s + {{16{inst[15]}}, inst[15:0]};
        T_LUI:   val = {inst[15:0], 16'h0};
        default: dst = 0;
      endcase
    end
    if (dst != 0) model_regs[dst] = val;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_program();
    for (int i = 0; i < 1024; i++) dut.u_rom.rom_mem[i] = 32'h0;
    foreach (prog[j]) dut.u_rom.rom_mem[j] = prog[j];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, dut.pc_q, 32'h0);
    check({tag, "_ce"}, 32'(mon_if.ce), 32'h0);
    check({tag, "_wb_wreg"}, 32'(dut.mem_wb_q.wreg), 32'h0);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_gpr%0d", tag, i), dut.regs_q[i], 32'h0);
  endtask

  // Assert reset at a falling edge for two cycles, checking the flush at once.
  task automatic enter_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset({tag, "_async"});
    @(negedge clk);
    check_reset({tag, "_held"});
  endtask

  // Release reset and check the first fetches.
  task automatic release_and_fetch(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_ce1"}, 32'(mon_if.ce), 32'h1);
    check({tag, "_pc0"}, dut.pc_q, 32'h0);
    check({tag, "_inst0"}, mon_if.inst, prog[0]);
    @(negedge clk);
    check({tag, "_pc4"}, dut.pc_q, 32'h4);
  endtask

  task automatic run_to_end();
    repeat (prog.size() + 6) @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    foreach (prog[j]) model_exec(prog[j]);
    for (int i = 0; i < NREG; i++) exp_q.push_back(model_regs[i]);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s_gpr%0d", tag, i), dut.regs_q[i], exp_q.pop_front());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset from time 0 for 200 ns
    prog = {};
    prog.push_back(enc_i(T_ORI, 0, 1, 16'h1100));
    prog.push_back(enc_i(T_ORI, 1, 2, 16'h0020));
    prog.push_back(enc_i(T_ORI, 2, 3, 16'h4400));
    prog.push_back(enc_i(T_ORI, 3, 4, 16'h0044));
    load_program();
    repeat (9) @(negedge clk);
    check_reset("rst0");

    // Back-to-back ori chain
    release_and_fetch("t2");
    run_to_end();
    check("t2_r1", dut.regs_q[1], 32'h0000_1100);
    check("t2_r2", dut.regs_q[2], 32'h0000_1120);
    check("t2_r3", dut.regs_q[3], 32'h0000_5520);
    check("t2_r4", dut.regs_q[4], 32'h0000_5564);
    compare_model("t2m");

    // Logic and lui
    enter_reset("t3rst");
    prog = {};
    prog.push_back(enc_i(T_LUI, 0, 1, 16'h0101));
    prog.push_back(enc_i(T_ORI, 1, 1, 16'h0101));
    prog.push_back(enc_i(T_XORI, 1, 2, 16'hFF00));
    prog.push_back(enc_r(F_NOR, 1, 0, 3, 0));
    load_program();
    release_and_fetch("t3");
    run_to_end();
    check("t3_r1", dut.regs_q[1], 32'h0101_0101);
    check("t3_r2", dut.regs_q[2], 32'h0101_FE01);
    check("t3_r3", dut.regs_q[3], 32'hFEFE_FEFE);
    compare_model("t3m");

    // Reset mid-run, then the same program again
    enter_reset("t6a");
    release_and_fetch("t6b");
    repeat (5) @(negedge clk);
    enter_reset("t6mid");
    release_and_fetch("t6c");
    run_to_end();
    check("t6_r1", dut.regs_q[1], 32'h0101_0101);
    check("t6_r2", dut.regs_q[2], 32'h0101_FE01);
    check("t6_r3", dut.regs_q[3], 32'hFEFE_FEFE);
    compare_model("t6m");

    // Arithmetic wrap-around
    enter_reset("t4rst");
    prog = {};
    prog.push_back(enc_i(T_ADDIU, 0, 1, 16'hFFFF));
    prog.push_back(enc_r(F_ADDU, 1, 1, 2, 0));
    prog.push_back(enc_r(F_SUBU, 0, 1, 3, 0));
    load_program();
    release_and_fetch("t4");
    run_to_end();
    check("t4_r1", dut.regs_q[1], 32'hFFFF_FFFF);
    check("t4_r2", dut.regs_q[2], 32'hFFFF_FFFE);
    check("t4_r3", dut.regs_q[3], 32'h0000_0001);
    compare_model("t4m");

    // Shifts, writes to $0, write-back bypass at distance 3
    enter_reset("t5rst");
    prog = {};
    prog.push_back(enc_i(T_LUI, 0, 1, 16'h8000));
    prog.push_back(enc_r(F_SRA, 0, 1, 2, 4));
    prog.push_back(enc_i(T_ORI, 0, 0, 16'h0005));
    prog.push_back(enc_r(F_ADDU, 0, 0, 5, 0));
    prog.push_back(enc_r(F_SRL, 0, 1, 3, 4));
    prog.push_back(enc_r(F_SLL, 0, 1, 4, 1));
    prog.push_back(enc_i(T_ORI, 0, 6, 16'h0007));
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(enc_r(F_ADDU, 6, 6, 7, 0));
    load_program();
    release_and_fetch("t5");
    run_to_end();
    check("t5_r0", dut.regs_q[0], 32'h0);
    check("t5_r1", dut.regs_q[1], 32'h8000_0000);
    check("t5_r2", dut.regs_q[2], 32'hF800_0000);
    check("t5_r3", dut.regs_q[3], 32'h0800_0000);
    check("t5_r4", dut.regs_q[4], 32'h0);
    check("t5_r5", dut.regs_q[5], 32'h0);
    check("t5_r7", dut.regs_q[7], 32'h0000_000E);
    compare_model("t5m");

    // Random programs over a small register set to force dense hazards
    for (int p = 0; p < 4; p++) begin
      enter_reset($sformatf("rnd%0drst", p));
      prog = {};
      for (int k = 0; k < 30; k++) prog.push_back(rand_inst());
      load_program();
      release_and_fetch($sformatf("rnd%0d", p));
      run_to_end();
      compare_model($sformatf("rnd%0dm", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
